// File: rtl/bank_responder.sv
// bank_responder: single-bank DRAM command responder with timing checks, auto-precharge and CL read pipeline
module bank_responder #(
  parameter int ADDR_BITS = 14,
  parameter int DATA_W = 16,
  parameter int T_RCD = 3,
  parameter int T_RP = 3,
  parameter int T_RAS = 6,
  parameter int CL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd_type,
  input  logic                 cmd_ap,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 viol_clr,
  output logic                 rd_valid,
  output logic [DATA_W-1:0]    rd_data,
  output logic [1:0]           bank_state,
  output logic [ADDR_BITS-1:0] open_row,
  output logic [3:0]           viol
);
  typedef enum logic [1:0] {IDLE, ACTIVATING, ACTIVE, PRECHARGING} state_t;
  state_t st, e;
  logic [3:0] rcd, rp, ras, new_viol, idx;
  logic ap_pending, is_act, is_rw, is_pre, act_ok, rw_ok, rd_ok, wr_ok, pre_go, ap_go;
  logic [DATA_W-1:0] mem [16];
  logic [CL-1:0] pv;
  logic [DATA_W-1:0] pd [CL];
  function automatic logic [3:0] dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction
  assign bank_state = st;
  // Effective state at this edge folds in timers that expire exactly now, then classifies the command
  always_comb begin
    e = (st == ACTIVATING && rcd == 4'd0) ? ACTIVE : (st == PRECHARGING && rp == 4'd0) ? IDLE : st;
    is_act = cmd_valid && cmd_type == 3'd1;
    is_rw = cmd_valid && (cmd_type == 3'd2 || cmd_type == 3'd3);
    is_pre = cmd_valid && cmd_type == 3'd4;
    act_ok = is_act && e == IDLE;
    rw_ok = is_rw && e == ACTIVE && !ap_pending;
    rd_ok = rw_ok && cmd_type == 3'd2;
    wr_ok = rw_ok && cmd_type == 3'd3;
    pre_go = is_pre && e == ACTIVE && !ap_pending && ras == 4'd0;
    ap_go = ap_pending && ras == 4'd0;
    new_viol = {cmd_valid && cmd_type > 3'd4, is_pre && e != IDLE && !pre_go, is_rw && !rw_ok, is_act && !act_ok};
    idx = {open_row[1:0], cmd_addr[1:0]};
  end
  // Bank state, timing counters, auto-precharge tracking and sticky violations
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      rcd <= '0;
      rp <= '0;
      ras <= '0;
      ap_pending <= 1'b0;
      open_row <= '0;
      viol <= '0;
    end else begin
      st <= act_ok ? ACTIVATING : (pre_go || ap_go) ? PRECHARGING : e;
      rcd <= act_ok ? 4'(T_RCD - 1) : dec(rcd);
      ras <= act_ok ? 4'(T_RAS - 1) : dec(ras);
      rp <= (pre_go || ap_go) ? 4'(T_RP - 1) : dec(rp);
      ap_pending <= (rw_ok && cmd_ap) ? 1'b1 : ap_go ? 1'b0 : ap_pending;
      open_row <= act_ok ? cmd_addr : open_row;
      viol <= (viol_clr ? 4'd0 : viol) | new_viol;
    end
  end
  // Storage survives reset; writes land at the WR edge so the next RD sees them
  always_ff @(posedge clk) begin
    if (wr_ok) mem[idx] <= wr_data;
  end
  // Read pipeline: CL stages plus output register puts data exactly CL edges after the RD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < CL; i++) pd[i] <= '0;
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      pv[0] <= rd_ok;
      pd[0] <= rd_ok ? mem[idx] : '0;
      for (int i = 1; i < CL; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      rd_valid <= pv[CL-1];
      rd_data <= pd[CL-1];
    end
  end
endmodule
